// File: rtl/step_acc_pkg.sv
// rtl/step_acc_pkg.sv - shared constants, types and lane skew helper for the step accumulator chain
package step_acc_pkg;

  localparam int ACC_WIDTH_DEFAULT   = 32;
  localparam int WORD_WIDTH_DEFAULT  = 16;
  localparam int LATENCY_ACCUMULATOR = 4;

  typedef logic signed [ACC_WIDTH_DEFAULT-1:0]  acc_t;
  typedef logic signed [WORD_WIDTH_DEFAULT-1:0] prod_t;

  // Cycles lane i trails the reference point; the step buffer skews its outputs by the same amount.
  function automatic int lane_delay(input int i);
    return i * (LATENCY_ACCUMULATOR - 2) + 1;
  endfunction

endpackage

// File: rtl/step_acc_lane.sv
// rtl/step_acc_lane.sv - one accumulator lane with carry register, bypass adder and output register
module step_acc_lane
  import step_acc_pkg::*;
#(
  parameter int WORD_WIDTH  = WORD_WIDTH_DEFAULT,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEFAULT,
  parameter int TUSER_WIDTH = 8,
  parameter bit HAS_PREV    = 1'b1,
  parameter bit IS_TAIL     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   is_1x1,
  input  logic                   mode_change,
  input  logic                   beat_valid,
  input  logic [WORD_WIDTH-1:0]  beat_data,
  input  logic                   beat_last,
  input  logic [TUSER_WIDTH-1:0] beat_user,
  input  logic                   prev_done,
  input  logic [ACC_WIDTH-1:0]   prev_sum,
  output logic                   done,
  output logic [ACC_WIDTH-1:0]   sum,
  output logic                   res_valid,
  output logic [ACC_WIDTH-1:0]   res_data,
  output logic [TUSER_WIDTH-1:0] res_user,
  output logic                   err
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] carry;
  logic                 carry_valid;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH-1:0] carry_in;
  logic                 cascade;
  logic                 carry_live;

  // Lane 0 never receives a carry; every other lane cascades only outside 1x1 mode.
  assign cascade    = !is_1x1 && HAS_PREV;
  // A pending carry is discarded on the very cycle the mode flips.
  assign carry_live = carry_valid && !mode_change;
  assign ext        = ACC_WIDTH'($signed(beat_data));
  assign done       = ce && beat_valid && beat_last;
  assign sum        = acc + ext + carry_in;

  // Pick the carry source (bypass wins over the stored carry) and flag protocol violations.
  always_comb begin
    carry_in = '0;
    err      = 1'b0;
    if (cascade) begin
      if (prev_done) begin
        carry_in = prev_sum;
      end else if (carry_live) begin
        carry_in = carry;
      end
      if (done && !prev_done && !carry_live) begin
        err = 1'b1;
      end
      if (prev_done && carry_live) begin
        err = 1'b1;
      end
    end
  end

  // Running sum of the current group; cleared on the last beat so the next group starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (ce && beat_valid) begin
      acc <= beat_last ? '0 : acc + ext;
    end
  end

  // Carry from the previous lane: captured when it completes ahead of us, consumed by our last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry       <= '0;
      carry_valid <= 1'b0;
    end else if (ce) begin
      if (mode_change) begin
        carry_valid <= 1'b0;
      end else if (cascade && prev_done && !done) begin
        carry       <= prev_sum;
        carry_valid <= 1'b1;
      end else if (done) begin
        carry_valid <= 1'b0;
      end
    end
  end

  // Result register: a one-cycle pulse for independent lanes or for the tail of a cascade.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_user  <= '0;
    end else if (ce) begin
      res_valid <= done && (is_1x1 || IS_TAIL);
      if (done) begin
        res_data <= sum;
        res_user <= beat_user;
      end
    end
  end

endmodule

// File: rtl/step_accumulator_chain.sv
// rtl/step_accumulator_chain.sv - STEPS cascaded accumulator lanes with 1x1 and nxm modes
module step_accumulator_chain
  import step_acc_pkg::*;
#(
  parameter int WORD_WIDTH  = WORD_WIDTH_DEFAULT,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEFAULT,
  parameter int STEPS       = 3,
  parameter int TUSER_WIDTH = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         aclken,
  input  logic                         is_1x1,
  input  logic [STEPS-1:0]             s_valid,
  input  logic [STEPS*WORD_WIDTH-1:0]  s_data,
  input  logic [STEPS-1:0]             s_last,
  input  logic [STEPS*TUSER_WIDTH-1:0] s_user,
  output logic [STEPS-1:0]             m_valid,
  output logic [STEPS*ACC_WIDTH-1:0]   m_data,
  output logic [STEPS*TUSER_WIDTH-1:0] m_user,
  output logic                         sync_err
);

  logic                 mode_q;
  logic                 mode_change;
  logic [STEPS-1:0]     lane_done;
  logic [STEPS-1:0]     lane_err;
  logic [ACC_WIDTH-1:0] lane_sum [STEPS];

  assign mode_change = (is_1x1 != mode_q);

  // Remember the mode so a toggle can be detected and stale carries dropped.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q <= 1'b0;
    end else if (aclken) begin
      mode_q <= is_1x1;
    end
  end

  // Sticky carry-protocol violation flag; only reset clears it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_err <= 1'b0;
    end else if (aclken && (|lane_err)) begin
      sync_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < STEPS; i++) begin : g_lane
    logic                 prev_done;
    logic [ACC_WIDTH-1:0] prev_sum;

    if (i == 0) begin : g_head
      assign prev_done = 1'b0;
      assign prev_sum  = '0;
    end else begin : g_link
      assign prev_done = lane_done[i-1];
      assign prev_sum  = lane_sum[i-1];
    end

    step_acc_lane #(
      .WORD_WIDTH  (WORD_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .TUSER_WIDTH (TUSER_WIDTH),
      .HAS_PREV    (i != 0),
      .IS_TAIL     (i == STEPS - 1)
    ) u_lane (
      .clk         (aclk),
      .rst_n       (aresetn),
      .ce          (aclken),
      .is_1x1      (is_1x1),
      .mode_change (mode_change),
      .beat_valid  (s_valid[i]),
      .beat_data   (s_data[i*WORD_WIDTH +: WORD_WIDTH]),
      .beat_last   (s_last[i]),
      .beat_user   (s_user[i*TUSER_WIDTH +: TUSER_WIDTH]),
      .prev_done   (prev_done),
      .prev_sum    (prev_sum),
      .done        (lane_done[i]),
      .sum         (lane_sum[i]),
      .res_valid   (m_valid[i]),
      .res_data    (m_data[i*ACC_WIDTH +: ACC_WIDTH]),
      .res_user    (m_user[i*TUSER_WIDTH +: TUSER_WIDTH]),
      .err         (lane_err[i])
    );
  end

endmodule

// File: tb/tb_step_accumulator_chain.sv
// tb/tb_step_accumulator_chain.sv - scoreboard bench for step_accumulator_chain
module tb_step_accumulator_chain;
  import step_acc_pkg::*;

  localparam int NS  = 3;
  localparam int WW  = 32;
  localparam int AW  = 32;
  localparam int UW  = 8;
  localparam int MAXC = 64;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            aclken = 1'b1;
  logic            is_1x1 = 1'b1;
  logic [NS-1:0]   s_valid = '0;
  logic [NS*WW-1:0] s_data = '0;
  logic [NS-1:0]   s_last = '0;
  logic [NS*UW-1:0] s_user = '0;
  logic [NS-1:0]   m_valid;
  logic [NS*AW-1:0] m_data;
  logic [NS*UW-1:0] m_user;
  logic            sync_err;

  step_accumulator_chain #(.WORD_WIDTH(WW), .ACC_WIDTH(AW), .STEPS(NS), .TUSER_WIDTH(UW)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .is_1x1(is_1x1),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_user(s_user),
    .m_valid(m_valid), .m_data(m_data), .m_user(m_user), .sync_err(sync_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int         lane;
    logic [31:0] data;
    logic [7:0]  user;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic ce_prev = 1'b0;

  logic        sv [NS][MAXC];
  logic [31:0] sd [NS][MAXC];
  logic        sl [NS][MAXC];
  logic [7:0]  su [NS][MAXC];
  int ncyc;
  int stall_at;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < NS; i++)
      for (int c = 0; c < MAXC; c++) begin
        sv[i][c] = 1'b0; sd[i][c] = '0; sl[i][c] = 1'b0; su[i][c] = '0;
      end
    ncyc = 0;
    stall_at = -1;
  endtask

  task automatic put(input int lane, input int cyc, input logic [31:0] val, input bit last);
    sv[lane][cyc] = 1'b1;
    sd[lane][cyc] = val;
    sl[lane][cyc] = last;
    su[lane][cyc] = 8'($urandom);
    if (cyc + 1 > ncyc) ncyc = cyc + 1;
  endtask

  // Reference: group sums per lane; in cascade mode the k-th groups of all lanes add up at the tail.
  task automatic model(input bit m1);
    logic [31:0] gs [NS][MAXC];
    logic [7:0]  gu [NS][MAXC];
    int          gn [NS];
    logic [31:0] run;
    logic [31:0] tot;
    exp_t e;
    for (int i = 0; i < NS; i++) begin
      gn[i] = 0;
      run = '0;
      for (int c = 0; c < ncyc; c++) begin
        if (sv[i][c]) begin
          run = run + sd[i][c];
          if (sl[i][c]) begin
            gs[i][gn[i]] = run;
            gu[i][gn[i]] = su[i][c];
            gn[i]++;
            run = '0;
          end
        end
      end
    end
    if (m1) begin
      for (int i = 0; i < NS; i++)
        for (int k = 0; k < gn[i]; k++) begin
          e.lane = i; e.data = gs[i][k]; e.user = gu[i][k];
          exp_q.push_back(e);
        end
    end else begin
      for (int k = 0; k < gn[NS-1]; k++) begin
        tot = '0;
        for (int i = 0; i < NS; i++)
          if (k < gn[i]) tot = tot + gs[i][k];
        e.lane = NS - 1; e.data = tot; e.user = gu[NS-1][k];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge aclk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge aclk);
  endtask

  task automatic run(input string name, input bit m1);
    model(m1);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge aclk); #1;
      for (int i = 0; i < NS; i++) begin
        s_valid[i] = sv[i][c];
        s_last[i]  = sl[i][c];
        s_data[i*WW +: WW] = sd[i][c];
        s_user[i*UW +: UW] = su[i][c];
      end
      if (c == stall_at) begin
        aclken = 1'b0;
        repeat (4) @(posedge aclk);
        #1 aclken = 1'b1;
      end
    end
    @(posedge aclk); #1;
    s_valid = '0; s_last = '0;
    drain(name);
  endtask

  initial begin
    int len;
    fork
      forever begin
        @(posedge aclk);
        ce_prev = aclken;
      end
      forever begin
        @(negedge aclk);
        if (aresetn && ce_prev) begin
          for (int i = 0; i < NS; i++) begin
            if (m_valid[i]) begin
              int idx;
              idx = -1;
              for (int k = 0; k < exp_q.size(); k++)
                if (idx < 0 && exp_q[k].lane == i) idx = k;
              checks++;
              if (idx < 0) begin
                errors++;
                $display("FAIL unexpected_m_valid lane %0d: got 1 expected 0 (data 0x%0h)", i, m_data[i*AW +: AW]);
              end else begin
                chk($sformatf("m_data_lane%0d", i), 64'(m_data[i*AW +: AW]), 64'(exp_q[idx].data));
                chk($sformatf("m_user_lane%0d", i), 64'(m_user[i*UW +: UW]), 64'(exp_q[idx].user));
                exp_q.delete(idx);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge aclk);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_data", 64'(m_data), 64'd0);
    chk("reset_sync_err", 64'(sync_err), 64'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    // 1x1: every lane sums {1,2,3}
    is_1x1 = 1'b1;
    clear_sched();
    for (int i = 0; i < NS; i++)
      for (int c = 0; c < 3; c++) put(i, c, 32'(c + 1), c == 2);
    run("one_by_one", 1'b1);
    chk("sync_err_1x1", 64'(sync_err), 64'd0);

    // nxm with nominal skew: 3 + 30 + 300
    is_1x1 = 1'b0;
    clear_sched();
    for (int i = 0; i < NS; i++) begin
      int b;
      b = lane_delay(i) - lane_delay(0);
      put(i, b, 32'(1 * (10 ** i)), 1'b0);
      put(i, b + 1, 32'(2 * (10 ** i)), 1'b1);
    end
    run("cascade", 1'b0);
    chk("sync_err_cascade", 64'(sync_err), 64'd0);

    // bypass: lanes 0 and 1 finish together
    clear_sched();
    put(0, 0, 32'd5, 1'b1);
    put(1, 0, 32'd7, 1'b1);
    put(2, 2, 32'd0, 1'b1);
    run("bypass", 1'b0);
    chk("sync_err_bypass", 64'(sync_err), 64'd0);

    // randomized groups in both modes
    for (int g = 0; g < 8; g++) begin
      clear_sched();
      is_1x1 = g[0];
      if (g[0]) begin
        for (int i = 0; i < NS; i++) begin
          int st;
          st = $urandom_range(0, 3);
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) put(i, st + k, $urandom, k == len - 1);
        end
      end else begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < NS; i++)
          for (int k = 0; k < len; k++)
            put(i, lane_delay(i) - 1 + k, $urandom, k == len - 1);
      end
      @(posedge aclk);
      run("random", g[0]);
    end
    chk("sync_err_random", 64'(sync_err), 64'd0);

    // back-to-back groups with wrap
    is_1x1 = 1'b1;
    clear_sched();
    put(0, 0, 32'h7FFF_FFFF, 1'b0);
    put(0, 1, 32'd1, 1'b1);
    put(0, 2, 32'd2, 1'b0);
    put(0, 3, 32'd3, 1'b1);
    run("wrap", 1'b1);

    // stall mid-group
    clear_sched();
    put(0, 0, 32'd10, 1'b0); put(0, 1, 32'd20, 1'b0); put(0, 2, 32'd30, 1'b1);
    put(1, 0, 32'd1, 1'b0);  put(1, 1, 32'd1, 1'b1);
    stall_at = 1;
    run("stall", 1'b1);

    // lane 1 finishes with no carry from lane 0
    is_1x1 = 1'b0;
    @(posedge aclk);
    clear_sched();
    put(1, 0, 32'd3, 1'b1);
    put(2, 2, 32'd4, 1'b1);
    run("missing_carry", 1'b0);
    chk("sync_err_set", 64'(sync_err), 64'd1);
    repeat (5) @(posedge aclk);
    chk("sync_err_sticky", 64'(sync_err), 64'd1);

    // reset in the middle of a group
    is_1x1 = 1'b1;
    @(posedge aclk); #1;
    s_valid = 3'b001; s_last = '0; s_data = 96'd9;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b0;
    #1;
    chk("midreset_m_valid", 64'(m_valid), 64'd0);
    chk("midreset_m_data", 64'(m_data), 64'd0);
    chk("midreset_m_user", 64'(m_user), 64'd0);
    chk("midreset_sync_err", 64'(sync_err), 64'd0);
    s_valid = '0;
    @(posedge aclk); #1 aresetn = 1'b1;
    clear_sched();
    put(0, 0, 32'd4, 1'b1);
    run("after_reset", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

endmodule
